// File: rtl/adc733_cfg_sched_if.sv
// adc733_cfg_sched_if
// Bundles the requester bus and the codec control-word handshake used by
// adc733_cfg_sched.
//   req          requester -> sched  per-requester write request (level)
//   req_reg      requester -> sched  3-bit register address, slice i per requester
//   req_data     requester -> sched  8-bit register data, slice i per requester
//   gnt          sched -> requester  one-hot owner of the current transaction
//   done         sched -> requester  one-cycle pulse, word accepted by the core
//   err          sched -> requester  one-cycle pulse, transaction timed out
//   control_word sched -> core       packed 16-bit control word
//   cw_valid     sched -> core       control_word is valid
//   word_sent    core -> sched       one-cycle pulse, word shifted out
//   busy         sched -> observers  scheduler not idle
// master: scheduler side. slave: requesters / codec core side.
interface adc733_cfg_sched_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_reg;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic [15:0]          control_word;
  logic                 cw_valid;
  logic                 word_sent;
  logic                 busy;

  modport master (
    input  req, req_reg, req_data, word_sent,
    output gnt, done, err, control_word, cw_valid, busy
  );

  modport slave (
    output req, req_reg, req_data, word_sent,
    input  gnt, done, err, control_word, cw_valid, busy
  );
endinterface

// File: rtl/adc733_cfg_sched.sv
// adc733_cfg_sched
// Round-robin scheduler sharing the ADC733 codec control-word path among
// NUM_REQ register-write requesters. The granted request is packed into a
// 16-bit control word, held until the codec core pulses word_sent or the
// timeout expires, and the owner gets a done or err pulse.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  adc733_cfg_sched_if.master (requester bus + codec handshake + busy)
//
// state  | meaning
// IDLE   | waiting for any req, round-robin search from ptr
// LOAD   | gnt asserted, control word captured from the owner's slice
// SEND   | cw_valid held, timeout counter running
// RESP   | done/err pulse to owner, pointer advanced past owner
module adc733_cfg_sched #(
  parameter int         NUM_REQ     = 3,
  parameter logic [2:0] DEV_ADDR    = 3'd0,
  parameter int         TIMEOUT_CYC = 4096
) (
  input logic                clk,
  input logic                rst,
  adc733_cfg_sched_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [NUM_REQ-1:0] done_q, done_n;
  logic [NUM_REQ-1:0] err_q, err_n;
  logic [15:0]        cw_q, cw_n;
  logic               cwv_q, cwv_n;

  logic [2:0]         reg_a  [NUM_REQ];
  logic [7:0]         data_a [NUM_REQ];

  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] own_sel;

  // Unpack the flat request buses so the owner's fields can be indexed.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reg_a[g]  = bus.req_reg[3*g +: 3];
    assign data_a[g] = bus.req_data[8*g +: 8];
  end

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    arb_hit = 1'b0;
    arb_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!arb_hit && bus.req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    own_sel      = '0;
    own_sel[idx] = 1'b1;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt_q;
    done_n  = '0;
    err_n   = '0;
    cw_n    = cw_q;
    cwv_n   = cwv_q;

    unique case (state)
      S_IDLE: begin
        if (arb_hit) begin
          idx_n          = arb_idx;
          gnt_n          = '0;
          gnt_n[arb_idx] = 1'b1;
          state_n        = S_LOAD;
        end
      end

      S_LOAD: begin
        cw_n    = {2'b10, DEV_ADDR, reg_a[idx], data_a[idx]};
        cwv_n   = 1'b1;
        cnt_n   = '0;
        state_n = S_SEND;
      end

      S_SEND: begin
        // word_sent is checked first so it wins a tie with the timeout.
        if (bus.word_sent) begin
          done_n  = own_sel;
          cwv_n   = 1'b0;
          gnt_n   = '0;
          state_n = S_RESP;
        end else if (cnt == CNT_LAST) begin
          err_n   = own_sel;
          cwv_n   = 1'b0;
          gnt_n   = '0;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_RESP: begin
        ptr_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      ptr    <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      cw_q   <= 16'h0000;
      cwv_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      gnt_q  <= gnt_n;
      done_q <= done_n;
      err_q  <= err_n;
      cw_q   <= cw_n;
      cwv_q  <= cwv_n;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.control_word = cw_q;
  assign bus.cw_valid     = cwv_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_adc733_cfg_sched.sv
// tb_adc733_cfg_sched
// Transaction-level bench for adc733_cfg_sched: directed scenarios followed
// by randomized requests, word_sent delays and data churn. Expected owner,
// control word, SEND length and outcome come from a round-robin model.
module tb_adc733_cfg_sched;

  localparam int         N   = 3;
  localparam logic [2:0] DEV = 3'd0;
  localparam int         TO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc733_cfg_sched_if #(.NUM_REQ(N)) bus ();

  adc733_cfg_sched #(
    .NUM_REQ    (N),
    .DEV_ADDR   (DEV),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          ptr_m  = 0;
  logic [15:0] last_cw;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_data(input int i, input logic [2:0] r, input logic [7:0] d);
    bus.req_reg[3*i +: 3]  = r;
    bus.req_data[8*i +: 8] = d;
  endtask

  task automatic rand_data(input int i);
    set_data(i, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_gnt"}, bus.gnt, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_err"}, bus.err, 0);
    check_val({tag, "_cwv"}, bus.cw_valid, 0);
  endtask

  // Called at a negedge with the DUT idle and bus.req nonzero. d is the
  // SEND cycle (0 = first cycle cw_valid is seen) on which word_sent is
  // driven; d >= TO means never. mode: 0 random requester reaction,
  // 1 owner keeps req with new data, 2 owner drops req.
  task automatic run_txn(input int d, input int mode, input bit scramble);
    int          exp_idx;
    int          len;
    int          exp_len;
    bit          ok;
    logic [15:0] exp_cw;
    exp_idx = pick(bus.req, ptr_m);
    @(negedge clk);
    check_val("gnt_load", bus.gnt, onehot(exp_idx));
    check_val("cwv_load", bus.cw_valid, 0);
    check_val("busy_load", bus.busy, 1);
    exp_cw = {2'b10, DEV, bus.req_reg[3*exp_idx +: 3], bus.req_data[8*exp_idx +: 8]};
    @(negedge clk);
    check_val("cwv_rise", bus.cw_valid, 1);
    last_cw = bus.control_word;
    len = 0;
    while (bus.cw_valid === 1'b1 && len < TO + 4) begin
      check_val("cw_hold", bus.control_word, exp_cw);
      check_val("gnt_hold", bus.gnt, onehot(exp_idx));
      bus.word_sent = (len == d);
      if (scramble) begin
        for (int i = 0; i < N; i++) rand_data(i);
      end
      len++;
      @(negedge clk);
    end
    bus.word_sent = 1'b0;
    ok      = (d < TO);
    exp_len = ok ? d + 1 : TO;
    check_val("send_len", len, exp_len);
    check_val("done_resp", bus.done, ok ? onehot(exp_idx) : '0);
    check_val("err_resp", bus.err, ok ? '0 : onehot(exp_idx));
    check_val("gnt_resp", bus.gnt, 0);
    check_val("busy_resp", bus.busy, 1);
    ptr_m = (exp_idx + 1) % N;
    case (mode)
      1: rand_data(exp_idx);
      2: bus.req[exp_idx] = 1'b0;
      default: begin
        if ($urandom_range(0, 1) == 1) bus.req[exp_idx] = 1'b0;
        else rand_data(exp_idx);
        for (int i = 0; i < N; i++) begin
          if (i != exp_idx && $urandom_range(0, 3) == 0) begin
            bus.req[i] = ~bus.req[i];
            if (bus.req[i]) rand_data(i);
          end
        end
      end
    endcase
    @(negedge clk);
    check_quiet("idle_after");
  endtask

  initial begin
    int d;
    int r;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    bus.word_sent = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_val("reset_cw", bus.control_word, 16'h0000);
    rst = 1'b0;

    // single write from requester 1
    set_data(1, 3'd2, 8'hA5);
    bus.req = 3'b010;
    run_txn(10, 2, 0);
    check_val("single_cw", last_cw, 16'h82A5);

    // unsolicited word_sent while idle
    for (int i = 0; i < 3; i++) begin
      bus.word_sent = 1'b1;
      @(negedge clk);
      check_val("unsol_done", bus.done, 0);
      check_val("unsol_busy", bus.busy, 0);
    end
    bus.word_sent = 1'b0;

    // round robin from a freshly reset pointer
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < N; i++) rand_data(i);
    bus.req = 3'b111;
    for (int t = 0; t < 5; t++) run_txn(3, 1, 0);

    // timeout on requester 2
    bus.req = 3'b100;
    run_txn(TO + 5, 2, 0);

    // word_sent on the last timeout cycle
    bus.req = 3'b001;
    run_txn(TO - 1, 2, 0);

    // data freeze while sending
    set_data(0, 3'd5, 8'h11);
    bus.req = 3'b001;
    run_txn(6, 2, 1);
    check_val("freeze_lsb", last_cw[7:0], 8'h11);

    // reset in the middle of SEND
    rand_data(0);
    rand_data(2);
    bus.req = 3'b101;
    r = pick(bus.req, ptr_m);
    @(negedge clk);
    check_val("rstmid_gnt", bus.gnt, onehot(r));
    @(negedge clk);
    check_val("rstmid_cwv", bus.cw_valid, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rstmid");
    check_val("rstmid_cw", bus.control_word, 16'h0000);
    rst   = 1'b0;
    ptr_m = 0;
    run_txn(2, 2, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (bus.req == '0) begin
        repeat ($urandom_range(1, 3)) begin
          bus.word_sent = 1'($urandom_range(0, 1));
          @(negedge clk);
          check_val("gap_done", bus.done, 0);
          check_val("gap_busy", bus.busy, 0);
        end
        bus.word_sent = 1'b0;
        for (int i = 0; i < N; i++) rand_data(i);
        bus.req = N'($urandom_range(1, (1 << N) - 1));
      end
      r = $urandom_range(0, 9);
      if (r < 6)      d = $urandom_range(0, 5);
      else if (r < 8) d = TO - 1;
      else            d = TO + $urandom_range(0, 2);
      run_txn(d, 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc733_cfg_sched.md
Name: adc733_cfg_sched

Overview:
Round-robin scheduler that shares the ADC733 codec control-word path among NUM_REQ register-write requesters, such as the power-up init sequencer, the gain/channel controller and the host register bridge. It packs the granted request into a 16-bit control word and presents it to the codec serial-port core. It then holds the word until the core pulses word_sent, or until a timeout expires, and reports completion or error to the owning requester. It sits between the requesters and the control_word/word_sent pair of the codec core, entirely in the clk domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DEV_ADDR, 3'd0, codec device address placed in control word bits 13:11
TIMEOUT_CYC, 4096, clk cycles allowed from cw_valid rise to word_sent before abort (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester write request, level, held until done/err
req_reg  in  3*NUM_REQ  register address (0=CRA..7=CRH), slice i for requester i
req_data  in  8*NUM_REQ  register data, slice i for requester i
gnt  out  NUM_REQ  one-hot owner of the current transaction
done  out  NUM_REQ  one-cycle pulse: word accepted by the codec core
err  out  NUM_REQ  one-cycle pulse: transaction aborted by timeout
control_word  out  16  {1'b1 ctrl, 1'b0 write, DEV_ADDR, reg, data}
cw_valid  out  1  control_word is valid and must be shifted out
word_sent  in  1  one-cycle pulse from the codec core, already synchronous to clk
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; gnt=0, done=0, err=0, cw_valid=0, control_word=16'h0, busy=0; rr pointer=0; timeout counter=0.
- Reset mid-transaction aborts silently: no done/err pulse. The requester must re-request.
- States: IDLE -> LOAD -> SEND -> RESP -> IDLE.
- IDLE:
  - If any req bit is high, select the first requester with req high, searching from index ptr upward modulo NUM_REQ.
  - Latch its index, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Assert gnt[idx].
  - Register control_word = {2'b10, DEV_ADDR, req_reg[idx], req_data[idx]}. The word is frozen from here on; later changes on the request bus are ignored.
  - Set cw_valid=1, clear the timeout counter, go to SEND.
- SEND:
  - Hold cw_valid, control_word and gnt stable.
  - Counter increments every cycle.
  - On word_sent=1: go to RESP with result=ok.
  - Else if counter==TIMEOUT_CYC-1: go to RESP with result=timeout.
  - If word_sent and the timeout coincide, word_sent wins (result=ok).
- RESP:
  - cw_valid=0, gnt=0.
  - Pulse done[idx] if result=ok, otherwise err[idx]; exactly one cycle.
  - ptr = (idx+1) mod NUM_REQ. Go to IDLE.
- word_sent while not in SEND is ignored.
- Requester rules:
  - Drop req in the cycle after seeing done/err, or keep it high to issue a further write with new data.
  - A requester still high in IDLE after its RESP is re-arbitrated, but at lowest priority because of pointer rotation.
- Latency:
  - req rise to cw_valid=1 is 2 cycles when idle (IDLE sample, then LOAD registers outputs).
  - word_sent to done is 1 cycle.
  - Minimum transaction length is 4 cycles.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- A req that deasserts before it is granted is simply not served. A req that deasserts while granted does not affect the transaction.
- Counter width is clog2(TIMEOUT_CYC). It does not wrap within a transaction.

Test Plan:
- Single write: NUM_REQ=3, req[1]=1, req_reg[1]=3'd2, req_data[1]=8'hA5, word_sent 10 cycles after cw_valid -> control_word=16'h82A5, gnt=3'b010 for the whole transaction, done[1] pulse 1 cycle after word_sent, err=0.
- Round-robin: req=3'b111 held, word_sent 3 cycles after each cw_valid -> grant order 0,1,2,0,1; done pulses in the same order.
- Timeout: TIMEOUT_CYC=16, req[2]=1, word_sent never asserted -> cw_valid high for exactly 16 cycles, then err[2] pulse, done=0, busy low the next cycle.
- Race: word_sent asserted on the final timeout cycle -> done pulse, no err.
- Data freeze: change req_data[0] from 8'h11 to 8'h22 while in SEND -> control_word keeps 8'h11 in bits 7:0; unsolicited word_sent in IDLE -> no done pulse.
- Reset mid-SEND: assert rst for 1 cycle -> next cycle all outputs zero, no done/err pulse; the pending req is re-granted starting from ptr=0.
